w_arb: RTL and testbench

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port (`w_inc`/`w_data`, gated by `w_full`) between `N_REQ` requesters in the write clock domain. A requester holds the port for a burst of up to `BURST_LEN` words before the grant rotates. The block sits directly in front of the write-pointer logic and the FIFO memory write port.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/w_arb_rr_pick.sv | 31 +++
 rtl/w_arb.sv | 96 +++++++++
 tb/tb_w_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared write/read-domain FIFO definitions: arbiter FSM encoding, default sizing and width helpers.
// Pure declarations; no timing or flow-control behaviour lives here.
package fifo_pkg;

  typedef enum logic {
    W_ARB_IDLE = 1'b0,
    W_ARB_OWN  = 1'b1
  } w_arb_state_t;

  localparam int W_ARB_N_REQ_DEF     = 4;
  localparam int W_ARB_BURST_LEN_DEF = 4;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_bits(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

  localparam int W_ARB_OWNER_BITS_DEF = idx_bits(W_ARB_N_REQ_DEF);
  localparam int W_ARB_CNT_BITS_DEF   = cnt_bits(W_ARB_BURST_LEN_DEF);

endpackage

// File: rtl/w_arb_rr_pick.sv
// Round-robin first-one finder: searches req starting at last+1, wrapping; purely combinational,
// zero latency, no backpressure of its own.
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int N_REQ    = W_ARB_N_REQ_DEF,
  localparam int IDX_BITS = idx_bits(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [IDX_BITS-1:0] last,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  logic [N_REQ-1:0] rot;

  // Rotate so bit 0 is the requester just after the previous owner.
  assign rot = N_REQ'({req, req} >> (int'(last) + 1));

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IDX_BITS'((int'(last) + 1 + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/w_arb.sv
// Round-robin owner of the FIFO write port, bursts of up to BURST_LEN words per grant.
// Grant one cycle after req in IDLE; w_full stalls the write without dropping the grant.
module w_arb
  import fifo_pkg::*;
#(
  parameter  int N_REQ      = W_ARB_N_REQ_DEF,
  parameter  int DATA_BITS  = 8,
  parameter  int BURST_LEN  = W_ARB_BURST_LEN_DEF,
  localparam int OWNER_BITS = idx_bits(N_REQ),
  localparam int CNT_BITS   = cnt_bits(BURST_LEN)
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  output logic [N_REQ-1:0]           grant,
  input  logic                       w_full,
  output logic                       w_inc,
  output logic [DATA_BITS-1:0]       w_data,
  output logic [OWNER_BITS-1:0]      owner,
  output logic                       busy
);

  w_arb_state_t          state_q, state_d;
  logic [OWNER_BITS-1:0] owner_d;
  logic [OWNER_BITS-1:0] last_q, last_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [N_REQ-1:0]      grant_d;
  logic                  pick_vld;
  logic [OWNER_BITS-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_vld),
    .idx   (pick_idx)
  );

  assign busy    = (state_q == W_ARB_OWN);
  // A word accepted in the reset cycle would be lost with the abandoned burst, so suppress it.
  assign w_inc   = busy & req[owner] & ~w_full & ~w_rst;
  assign w_data  = busy ? req_data[int'(owner)*DATA_BITS +: DATA_BITS] : '0;
  assign cnt_inc = cnt_q + CNT_BITS'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    unique case (state_q)
      W_ARB_IDLE: begin
        if (pick_vld) begin
          state_d = W_ARB_OWN;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          grant_d = N_REQ'(1) << pick_idx;
        end
      end
      W_ARB_OWN: begin
        if (!req[owner]) begin
          state_d = W_ARB_IDLE;
          grant_d = '0;
        end else if (w_inc) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_BITS'(BURST_LEN)) begin
            state_d = W_ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = W_ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= W_ARB_IDLE;
      owner   <= '0;
      last_q  <= OWNER_BITS'(N_REQ - 1);
      cnt_q   <= '0;
      grant   <= '0;
    end else begin
      state_q <= state_d;
      owner   <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
    end
  end

endmodule

// File: tb/tb_w_arb.sv
// Scoreboarded bench for w_arb: a 4-requester/burst-4 instance and a 2-requester/burst-1 instance.
module tb_w_arb;

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic        w_rst1, w_full1, w_inc1, busy1;
  logic [3:0]  req1, grant1;
  logic [31:0] req_data1;
  logic [7:0]  w_data1;
  logic [1:0]  owner1;

  logic        w_rst2, w_full2, w_inc2, busy2;
  logic [1:0]  req2, grant2;
  logic [15:0] req_data2;
  logic [7:0]  w_data2;
  logic [0:0]  owner2;

  w_arb #(.N_REQ(4), .DATA_BITS(8), .BURST_LEN(4)) dut1 (
    .w_clk(w_clk), .w_rst(w_rst1), .req(req1), .req_data(req_data1), .grant(grant1),
    .w_full(w_full1), .w_inc(w_inc1), .w_data(w_data1), .owner(owner1), .busy(busy1)
  );

  w_arb #(.N_REQ(2), .DATA_BITS(8), .BURST_LEN(1)) dut2 (
    .w_clk(w_clk), .w_rst(w_rst2), .req(req2), .req_data(req_data2), .grant(grant2),
    .w_full(w_full2), .w_inc(w_inc2), .w_data(w_data2), .owner(owner2), .busy(busy2)
  );

  typedef struct {
    int         idx;
    logic [7:0] dat;
  } exp_t;

  exp_t       exp1[$], exp2[$];
  logic [7:0] tr1[$], tr2[$], etr[$];
  int         n_chk = 0;
  int         n_fail = 0;

  logic [7:0] words1[4][16];
  logic [7:0] words2[2][16];
  int         head1[4], tail1[4], head2[2], tail2[2];
  logic [3:0] acc1 = 4'h0;
  logic [1:0] acc2 = 2'h0;

  // Trace entry: {busy, owner, w_inc, grant}; o < 0 means idle.
  function automatic logic [7:0] ent(input int o, input bit inc);
    if (o < 0) return 8'h00;
    return {1'b1, 2'(o), inc, 4'(1 << o)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge w_clk);
    #2;
  endtask

  task automatic refresh();
    for (int r = 0; r < 4; r++) begin
      req1[r] = (head1[r] < tail1[r]);
      req_data1[r*8 +: 8] = (head1[r] < tail1[r]) ? words1[r][head1[r]] : 8'h00;
    end
    for (int r = 0; r < 2; r++) begin
      req2[r] = (head2[r] < tail2[r]);
      req_data2[r*8 +: 8] = (head2[r] < tail2[r]) ? words2[r][head2[r]] : 8'h00;
    end
  endtask

  task automatic load1(input int r, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      words1[r][tail1[r]] = base + 8'(j);
      tail1[r]++;
    end
  endtask

  task automatic load2(input int r, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      words2[r][tail2[r]] = base + 8'(j);
      tail2[r]++;
    end
  endtask

  task automatic exp_push(input int dut, input int idx, input logic [7:0] base, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.idx = idx;
      e.dat = base + 8'(j);
      if (dut == 1) exp1.push_back(e);
      else exp2.push_back(e);
    end
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    repeat (n) etr.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_tr(input string name, input int dut);
    int         n, bad;
    logic [7:0] g, bg, bw;
    n   = (dut == 1) ? tr1.size() : tr2.size();
    bad = -1;
    bg  = 8'h00;
    bw  = 8'h00;
    n_chk++;
    if (n != etr.size()) begin
      n_fail++;
      $display("FAIL %s trace length: got %0d cycles want %0d", name, n, etr.size());
    end else begin
      for (int i = 0; i < n; i++) begin
        g = (dut == 1) ? tr1[i] : tr2[i];
        if (g !== etr[i] && bad < 0) begin
          bad = i;
          bg  = g;
          bw  = etr[i];
        end
      end
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s trace cycle %0d: got %h want %h", name, bad, bg, bw);
      end
    end
    etr.delete();
  endtask

  task automatic begin1();
    w_rst1 = 1'b1;
    step(2);
    chk("rst grant", {4'h0, grant1}, 8'h00);
    chk("rst w_inc", {7'h0, w_inc1}, 8'h00);
    chk("rst w_data", w_data1, 8'h00);
    chk("rst owner", {6'h0, owner1}, 8'h00);
    chk("rst busy", {7'h0, busy1}, 8'h00);
    for (int r = 0; r < 4; r++) begin
      head1[r] = 0;
      tail1[r] = 0;
    end
  endtask

  task automatic go1();
    tr1.delete();
    w_rst1 = 1'b0;
  endtask

  // Requester model: pop the accepted word after each edge, present the next one.
  initial begin
    forever begin
      @(posedge w_clk);
      #1;
      for (int r = 0; r < 4; r++) if (acc1[r]) head1[r]++;
      for (int r = 0; r < 2; r++) if (acc2[r]) head2[r]++;
      refresh();
    end
  end

  // Monitor: record cycle traces and score every write against the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge w_clk);
      acc1 = (w_inc1 === 1'b1) ? grant1 : 4'h0;
      acc2 = (w_inc2 === 1'b1) ? grant2 : 2'h0;
      tr1.push_back({busy1, busy1 ? owner1 : 2'b00, w_inc1, grant1});
      tr2.push_back({busy2, busy2 ? {1'b0, owner2} : 2'b00, w_inc2, 2'b00, grant2});
      if (w_inc1 === 1'b1) begin
        n_chk++;
        if (exp1.size() == 0) begin
          n_fail++;
          $display("FAIL wr1 unexpected: got grant %b data %h want no write", grant1, w_data1);
        end else begin
          e = exp1.pop_front();
          if (w_data1 !== e.dat || grant1 !== 4'(1 << e.idx)) begin
            n_fail++;
            $display("FAIL wr1: got grant %b data %h want grant %b data %h",
                     grant1, w_data1, 4'(1 << e.idx), e.dat);
          end
        end
      end
      if (w_inc2 === 1'b1) begin
        n_chk++;
        if (exp2.size() == 0) begin
          n_fail++;
          $display("FAIL wr2 unexpected: got grant %b data %h want no write", grant2, w_data2);
        end else begin
          e = exp2.pop_front();
          if (w_data2 !== e.dat || grant2 !== 2'(1 << e.idx)) begin
            n_fail++;
            $display("FAIL wr2: got grant %b data %h want grant %b data %h",
                     grant2, w_data2, 2'(1 << e.idx), e.dat);
          end
        end
      end
    end
  end

  initial begin
    w_rst1  = 1'b1;
    w_rst2  = 1'b1;
    w_full1 = 1'b0;
    w_full2 = 1'b0;
    for (int r = 0; r < 4; r++) begin head1[r] = 0; tail1[r] = 0; end
    for (int r = 0; r < 2; r++) begin head2[r] = 0; tail2[r] = 0; end
    refresh();

    // Single requester: two back-to-back bursts split by one idle cycle.
    begin1();
    load1(2, 8'hA0, 8);
    refresh();
    exp_push(1, 2, 8'hA0, 8);
    go1();
    step(11);
    push_n(ent(-1, 0), 1); push_n(ent(2, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(2, 1), 4);  push_n(ent(-1, 0), 1);
    check_tr("single", 1);

    // Rotation with all four requesting.
    begin1();
    load1(0, 8'h10, 8); load1(1, 8'h20, 4); load1(2, 8'h30, 4); load1(3, 8'h40, 4);
    refresh();
    exp_push(1, 0, 8'h10, 4); exp_push(1, 1, 8'h20, 4); exp_push(1, 2, 8'h30, 4);
    exp_push(1, 3, 8'h40, 4); exp_push(1, 0, 8'h14, 4);
    go1();
    step(26);
    push_n(ent(-1, 0), 1);
    push_n(ent(0, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(1, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(2, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(3, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(0, 1), 4); push_n(ent(-1, 0), 1);
    check_tr("rotation", 1);

    // Full stall after two writes; burst finishes with exactly two more.
    begin1();
    load1(1, 8'h50, 6);
    refresh();
    exp_push(1, 1, 8'h50, 6);
    go1();
    step(3);
    w_full1 = 1'b1;
    step(3);
    w_full1 = 1'b0;
    step(7);
    push_n(ent(-1, 0), 1); push_n(ent(1, 1), 2); push_n(ent(1, 0), 3);
    push_n(ent(1, 1), 2);  push_n(ent(-1, 0), 1); push_n(ent(1, 1), 2);
    push_n(ent(1, 0), 1);  push_n(ent(-1, 0), 1);
    check_tr("full stall", 1);

    // Early release by requester 1 hands over to pending requester 3.
    begin1();
    load1(1, 8'h60, 2); load1(3, 8'h70, 4);
    refresh();
    exp_push(1, 1, 8'h60, 2); exp_push(1, 3, 8'h70, 4);
    go1();
    step(10);
    push_n(ent(-1, 0), 1); push_n(ent(1, 1), 2); push_n(ent(1, 0), 1);
    push_n(ent(-1, 0), 1); push_n(ent(3, 1), 4); push_n(ent(-1, 0), 1);
    check_tr("early release", 1);

    // Reset during the third word of requester 2; requester 0 wins afterwards.
    begin1();
    load1(2, 8'h80, 4);
    refresh();
    exp_push(1, 2, 8'h80, 2); exp_push(1, 0, 8'h90, 4); exp_push(1, 2, 8'h82, 2);
    go1();
    step(3);
    w_rst1 = 1'b1;
    load1(0, 8'h90, 4);
    refresh();
    step(1);
    w_rst1 = 1'b0;
    step(10);
    push_n(ent(-1, 0), 1); push_n(ent(2, 1), 2); push_n(ent(2, 0), 1);
    push_n(ent(-1, 0), 1); push_n(ent(0, 1), 4); push_n(ent(-1, 0), 1);
    push_n(ent(2, 1), 2);  push_n(ent(2, 0), 1); push_n(ent(-1, 0), 1);
    check_tr("reset mid-burst", 1);

    // Two requesters, one-word bursts: strict alternation with owner wrap.
    w_rst2 = 1'b1;
    step(2);
    chk("rst2 grant", {6'h0, grant2}, 8'h00);
    chk("rst2 w_inc", {7'h0, w_inc2}, 8'h00);
    chk("rst2 busy", {7'h0, busy2}, 8'h00);
    for (int r = 0; r < 2; r++) begin head2[r] = 0; tail2[r] = 0; end
    load2(0, 8'hC0, 4); load2(1, 8'hD0, 4);
    refresh();
    for (int m = 0; m < 4; m++) begin
      exp_push(2, 0, 8'hC0 + 8'(m), 1);
      exp_push(2, 1, 8'hD0 + 8'(m), 1);
    end
    tr2.delete();
    w_rst2 = 1'b0;
    step(17);
    push_n(ent(-1, 0), 1);
    for (int m = 0; m < 4; m++) begin
      push_n(ent(0, 1), 1); push_n(ent(-1, 0), 1);
      push_n(ent(1, 1), 1); push_n(ent(-1, 0), 1);
    end
    check_tr("n2 burst1 alternation", 2);

    chk("wr1 leftover expected", 8'(exp1.size()), 8'h00);
    chk("wr2 leftover expected", 8'(exp2.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
